tri_raster: RTL and testbench
=============================

TRI_RASTER -- requirements
Module: tri_raster

Interface
REQ-001 SHALL have parameter SCR_W, default 640, screen width in pixels.
REQ-002 SHALL have parameter SCR_H, default 480, screen height in pixels.
REQ-003 SHALL have parameter CW, default 6, colour width in bits.
REQ-004 SHALL have parameter XW, default 10, vertex X and Y coordinate width (unsigned).
REQ-005 SHALL have parameter AW, default 19, pixel address width.
REQ-006 Ports SHALL be as follows; reset is synchronous and active-high, the clock is clk:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- tri_valid  in  1  triangle offered
- tri_ready  out  1  triangle accepted when both high
- tri_data  in  6*XW+CW  {v0x,v0y,v1x,v1y,v2x,v2y,color}, MSB first
- cull_back  in  1  discard clockwise-wound triangles, sampled at accept
- px_valid  out  1  pixel write pending
- px_ready  in  1  sink takes pixel when both high
- px_addr  out  AW  y*SCR_W+x
- px_color  out  CW  triangle colour
- busy  out  1  not in IDLE
- done  out  1  one-cycle pulse per accepted triangle

Function
REQ-007 States SHALL be IDLE, SETUP, SCAN, DRAIN.
REQ-008 tri_ready SHALL be 1 only in IDLE.
- Acceptance in IDLE latches vertices, colour and cull_back, then moves to SETUP.
REQ-009 SETUP SHALL take one cycle and compute the bounding box.
- min/max of the vertex X and Y values.
- Clipped inclusive to [0,SCR_W-1] x [0,SCR_H-1].
REQ-010 SETUP SHALL compute signed area A = (v1x-v0x)*(v2y-v0y) - (v1y-v0y)*(v2x-v0x).
- Signed arithmetic, 2*XW+3 bits, no overflow.
REQ-011 SETUP SHALL discard the triangle, pulse done next cycle and return to IDLE when any of these holds:
- A == 0.
- cull_back=1 and A<0.
- The bounding box lies wholly off-screen (min > clip max).
REQ-012 Otherwise SETUP SHALL set x=xmin, y=ymin and enter SCAN.
REQ-013 SCAN SHALL visit every (x,y) in the box, inclusive of xmax and ymax, row-major, at one pixel per cycle when not stalled.
REQ-014 A pixel SHALL be covered when all three edge values E01, E12, E20 have the same sign as A or equal zero.
- E(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax).
REQ-015 A covered pixel SHALL load an output register the cycle after evaluation: px_valid=1, px_addr, px_color.
- Uncovered pixels produce nothing.
REQ-016 While px_valid=1 and px_ready=0, the scan position and the output register SHALL hold.
- No pixel is dropped or duplicated.
REQ-017 After (xmax,ymax) is evaluated, the block SHALL enter DRAIN.
- It stays in DRAIN until the output register is empty.
- done then pulses for one cycle and the block returns to IDLE.
REQ-018 Latency SHALL be as follows (accept at cycle T):
- SETUP at T+1.
- First evaluation at T+2.
- Earliest px_valid at T+3.
REQ-019 px_addr SHALL be computed modulo 2^AW from clipped coordinates only.

Reset
REQ-020 Reset SHALL force the following the next edge, including mid-SCAN; any in-flight triangle is abandoned without a done pulse:
- state=IDLE
- px_valid=0
- done=0
- busy=0
REQ-021 tri_ready SHALL be 0 while reset is high and 1 the cycle after reset is released.

Structure
REQ-022 Package gpu_pkg SHALL hold the following:
- Default screen constants.
- State encoding.
- The tri_data field offset constants.
REQ-023 Three instances of sub-module edge_eval SHALL compute the edge values combinationally.
- Inputs: two vertices and a point.
- Output: signed E.

Verification
REQ-024 Triangle (0,0),(3,0),(0,3), colour 0x15, px_ready=1 -> exactly 10 pixels, first addr 0, last addr 1920, then one done pulse.
REQ-025 Collinear (0,0),(2,2),(4,4) -> zero px_valid cycles, done pulse at T+2.
REQ-026 Triangle (0,0),(0,3),(3,0):
- cull_back=1 -> no pixels, done pulse.
- cull_back=0 -> the same 10 addresses as REQ-024.
REQ-027 REQ-024 triangle with px_ready toggling every cycle -> identical 10 addresses in identical order, no repeats, px_addr stable while stalled.
REQ-028 Triangle (630,0),(700,0),(630,5) -> no px_addr with x>639, and (639,0) emitted as addr 639.
REQ-029 Reset asserted mid-SCAN -> next cycle px_valid=0 and busy=0, tri_ready=1 after release, no done pulse.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared screen defaults, raster FSM encoding and tri_data field slots.
// tri_data slot n of a vertex coordinate sits at bit offset CW + n*XW; colour occupies [CW-1:0].
package gpu_pkg;
  localparam int SCR_W_DEF = 640;
  localparam int SCR_H_DEF = 480;
  localparam int CW_DEF = 6;
  localparam int XW_DEF = 10;
  localparam int AW_DEF = 19;
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} state_t;
  localparam int F_V0X = 5;
  localparam int F_V0Y = 4;
  localparam int F_V1X = 3;
  localparam int F_V1Y = 2;
  localparam int F_V2X = 1;
  localparam int F_V2Y = 0;
endpackage

// File: rtl/edge_eval.sv
// edge_eval: signed edge function E = (bx-ax)*(py-ay) - (by-ay)*(px-ax).
// Ports: ax/ay, bx/by edge endpoints, px/py test point (all unsigned XW), e signed 2*XW+3 result.
module edge_eval #(
  parameter int XW = 10
) (
  input  logic [XW-1:0]          ax,
  input  logic [XW-1:0]          ay,
  input  logic [XW-1:0]          bx,
  input  logic [XW-1:0]          by,
  input  logic [XW-1:0]          px,
  input  logic [XW-1:0]          py,
  output logic signed [2*XW+2:0] e
);
  localparam int EW = 2*XW + 3;
  function automatic logic signed [EW-1:0] ext(input logic [XW-1:0] v);
    return $signed({{(EW-XW){1'b0}}, v});
  endfunction
  logic signed [EW-1:0] dxb, dyb, dxp, dyp;
  assign dxb = ext(bx) - ext(ax);
  assign dyb = ext(by) - ext(ay);
  assign dxp = ext(px) - ext(ax);
  assign dyp = ext(py) - ext(ay);
  assign e = dxb * dyp - dyb * dxp;
endmodule

// File: rtl/tri_raster.sv
// tri_raster: bounding-box triangle rasteriser emitting one covered pixel address per cycle.
// Ports: tri_valid/tri_ready/tri_data/cull_back triangle input, px_valid/px_ready/px_addr/px_color
// pixel output, busy while not idle, done pulses once per accepted triangle.
module tri_raster
  import gpu_pkg::*;
#(
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF,
  parameter int CW = CW_DEF,
  parameter int XW = XW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tri_valid,
  output logic              tri_ready,
  input  logic [6*XW+CW-1:0] tri_data,
  input  logic              cull_back,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [AW-1:0]     px_addr,
  output logic [CW-1:0]     px_color,
  output logic              busy,
  output logic              done
);
  localparam int EW = 2*XW + 3;
  localparam logic [XW-1:0] XLIM = XW'(SCR_W - 1);
  localparam logic [XW-1:0] YLIM = XW'(SCR_H - 1);
  function automatic logic [XW-1:0] mn(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return a < b ? a : b;
  endfunction
  function automatic logic [XW-1:0] mx(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return a > b ? a : b;
  endfunction
  function automatic logic inside_edge(input logic signed [EW-1:0] e, input logic neg);
    return neg ? (e[EW-1] || e == '0) : !e[EW-1];
  endfunction
  state_t state_q, state_d;
  logic [XW-1:0] vx_q [3], vx_d [3], vy_q [3], vy_d [3];
  logic [CW-1:0] col_q, col_d;
  logic cull_q, cull_d, neg_q, neg_d, pv_q, pv_d, done_q, done_d;
  logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d, x_q, x_d, y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [XW-1:0] ptx, pty, xlo, xhi, ylo, yhi;
  logic signed [EW-1:0] e01, e12, e20;
  logic cov, stall, row_end;
  // During SETUP the first edge unit sees v2 as its point, which yields the signed area.
  assign ptx = state_q == SETUP ? vx_q[2] : x_q;
  assign pty = state_q == SETUP ? vy_q[2] : y_q;
  edge_eval #(.XW(XW)) u_e01 (.ax(vx_q[0]), .ay(vy_q[0]), .bx(vx_q[1]), .by(vy_q[1]), .px(ptx), .py(pty), .e(e01));
  edge_eval #(.XW(XW)) u_e12 (.ax(vx_q[1]), .ay(vy_q[1]), .bx(vx_q[2]), .by(vy_q[2]), .px(ptx), .py(pty), .e(e12));
  edge_eval #(.XW(XW)) u_e20 (.ax(vx_q[2]), .ay(vy_q[2]), .bx(vx_q[0]), .by(vy_q[0]), .px(ptx), .py(pty), .e(e20));
  assign xlo = mn(mn(vx_q[0], vx_q[1]), vx_q[2]);
  assign xhi = mx(mx(vx_q[0], vx_q[1]), vx_q[2]);
  assign ylo = mn(mn(vy_q[0], vy_q[1]), vy_q[2]);
  assign yhi = mx(mx(vy_q[0], vy_q[1]), vy_q[2]);
  assign cov = inside_edge(e01, neg_q) && inside_edge(e12, neg_q) && inside_edge(e20, neg_q);
  assign stall = pv_q && !px_ready;
  assign row_end = x_q == xmax_q;
  always_comb begin
    state_d = state_q;
    vx_d = vx_q;
    vy_d = vy_q;
    col_d = col_q;
    cull_d = cull_q;
    neg_d = neg_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymax_d = ymax_q;
    x_d = x_q;
    y_d = y_q;
    addr_d = addr_q;
    pv_d = stall;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (tri_valid) begin
        vx_d[0] = tri_data[CW+F_V0X*XW +: XW];
        vy_d[0] = tri_data[CW+F_V0Y*XW +: XW];
        vx_d[1] = tri_data[CW+F_V1X*XW +: XW];
        vy_d[1] = tri_data[CW+F_V1Y*XW +: XW];
        vx_d[2] = tri_data[CW+F_V2X*XW +: XW];
        vy_d[2] = tri_data[CW+F_V2Y*XW +: XW];
        col_d = tri_data[CW-1:0];
        cull_d = cull_back;
        state_d = SETUP;
      end
      SETUP: begin
        neg_d = e01[EW-1];
        xmin_d = xlo;
        xmax_d = mn(xhi, XLIM);
        ymax_d = mn(yhi, YLIM);
        x_d = xlo;
        y_d = ylo;
        done_d = e01 == '0 || (cull_q && e01[EW-1]) || xlo > XLIM || ylo > YLIM;
        state_d = done_d ? IDLE : SCAN;
      end
      SCAN: if (!stall) begin
        pv_d = cov;
        addr_d = cov ? AW'(32'(y_q) * 32'(SCR_W) + 32'(x_q)) : addr_q;
        x_d = row_end ? xmin_q : x_q + 1'b1;
        y_d = row_end ? y_q + 1'b1 : y_q;
        state_d = row_end && y_q == ymax_q ? DRAIN : SCAN;
      end
      DRAIN: begin
        done_d = !pv_q;
        state_d = pv_q ? DRAIN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    pv_q <= reset ? 1'b0 : pv_d;
    done_q <= reset ? 1'b0 : done_d;
    vx_q <= vx_d;
    vy_q <= vy_d;
    col_q <= col_d;
    cull_q <= cull_d;
    neg_q <= neg_d;
    xmin_q <= xmin_d;
    xmax_q <= xmax_d;
    ymax_q <= ymax_d;
    x_q <= x_d;
    y_q <= y_d;
    addr_q <= addr_d;
  end
  assign tri_ready = state_q == IDLE && !reset;
  assign busy = state_q != IDLE;
  assign px_valid = pv_q;
  assign px_addr = addr_q;
  assign px_color = col_q;
  assign done = done_q;
endmodule

// File: tb/tb_tri_raster.sv
// tb_tri_raster: scoreboard bench for tri_raster with a reference coverage model.
module tb_tri_raster;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tri_valid = 1'b0;
  logic cull_back = 1'b0;
  logic px_ready = 1'b1;
  logic [65:0] tri_data = '0;
  logic tri_ready, px_valid, busy, done;
  logic [18:0] px_addr;
  logic [5:0] px_color;
  int n_chk = 0, n_fail = 0, cyc = 0, rdy_mode = 0;
  int exp_q[$];
  logic [5:0] exp_col = '0;
  int px_cnt, done_cnt = 0, first_pv, done_cyc, acc_cyc, first_addr, last_addr, exp_n, d0;
  bit seen639;

  tri_raster dut (
    .clk(clk), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data),
    .cull_back(cull_back), .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr),
    .px_color(px_color), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int edgef(int ax, int ay, int bx, int by, int px, int py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  task automatic model(input int vx[3], input int vy[3], input bit cull, output int n);
    int a, xlo, xhi, ylo, yhi, e0, e1, e2;
    a = edgef(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
    xlo = vx[0]; xhi = vx[0]; ylo = vy[0]; yhi = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < xlo) xlo = vx[i];
      if (vx[i] > xhi) xhi = vx[i];
      if (vy[i] < ylo) ylo = vy[i];
      if (vy[i] > yhi) yhi = vy[i];
    end
    n = 0;
    if (a == 0 || (cull && a < 0) || xlo > 639 || ylo > 479) return;
    if (xhi > 639) xhi = 639;
    if (yhi > 479) yhi = 479;
    for (int y = ylo; y <= yhi; y++)
      for (int x = xlo; x <= xhi; x++) begin
        e0 = edgef(vx[0], vy[0], vx[1], vy[1], x, y);
        e1 = edgef(vx[1], vy[1], vx[2], vy[2], x, y);
        e2 = edgef(vx[2], vy[2], vx[0], vy[0], x, y);
        if (a > 0 ? (e0 >= 0 && e1 >= 0 && e2 >= 0) : (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
          exp_q.push_back(y * 640 + x);
          n++;
        end
      end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    px_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~px_ready : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) if (!reset) begin
    if (px_valid) begin
      if (first_pv < 0) first_pv = cyc;
      if (exp_q.size() == 0) chk("px_unexpected", px_valid, 1'b0);
      else begin
        chk("px_addr", px_addr, exp_q[0]);
        chk("px_color", px_color, exp_col);
        if (px_ready) begin
          void'(exp_q.pop_front());
          if (px_cnt == 0) first_addr = px_addr;
          last_addr = px_addr;
          if (px_addr == 19'd639) seen639 = 1'b1;
          px_cnt++;
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2,
                       input logic [5:0] col, input bit cull);
    int vx[3] = '{x0, x1, x2};
    int vy[3] = '{y0, y1, y2};
    int n = 0;
    model(vx, vy, cull, exp_n);
    exp_col = col;
    px_cnt = 0; first_pv = -1; done_cyc = -1; seen639 = 1'b0; d0 = done_cnt;
    @(negedge clk);
    while (!tri_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", tri_ready, 1'b1);
    acc_cyc = cyc;
    tri_data = {10'(x0), 10'(y0), 10'(x1), 10'(y1), 10'(x2), 10'(y2), col};
    cull_back = cull;
    tri_valid = 1'b1;
    @(posedge clk);
    #1 tri_valid = 1'b0;
  endtask

  task automatic finish_tri(input int want_px);
    int n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done_cnt > d0, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("px_count", px_cnt, want_px);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tri_ready", tri_ready, 1'b0);
    chk("rst_px_valid", px_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_tri_ready", tri_ready, 1'b1);
    start(0, 0, 3, 0, 0, 3, 6'h15, 1'b0);
    finish_tri(10);
    chk("ccw_first_lat", first_pv - acc_cyc, 3);
    chk("ccw_first_addr", first_addr, 0);
    chk("ccw_last_addr", last_addr, 1920);
    start(0, 0, 2, 2, 4, 4, 6'h2a, 1'b0);
    finish_tri(0);
    chk("collinear_done_lat", done_cyc - acc_cyc, 2);
    start(0, 0, 0, 3, 3, 0, 6'h07, 1'b1);
    finish_tri(0);
    start(0, 0, 0, 3, 3, 0, 6'h15, 1'b0);
    finish_tri(10);
    chk("cw_last_addr", last_addr, 1920);
    rdy_mode = 1;
    start(0, 0, 3, 0, 0, 3, 6'h15, 1'b0);
    finish_tri(10);
    chk("stall_first_addr", first_addr, 0);
    chk("stall_last_addr", last_addr, 1920);
    rdy_mode = 0;
    start(630, 0, 700, 0, 630, 5, 6'h3f, 1'b0);
    finish_tri(exp_n);
    chk("clip_seen639", seen639, 1'b1);
    start(650, 0, 700, 0, 650, 10, 6'h01, 1'b0);
    finish_tri(0);
    rdy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      start($urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 24),
            k == 5 ? 630 : $urandom_range(0, 24), $urandom_range(470, 490) - (k < 4 ? 470 : 0),
            6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      finish_tri(exp_n);
    end
    rdy_mode = 0;
    start(0, 0, 40, 0, 0, 40, 6'h11, 1'b0);
    repeat (30) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_px_valid", px_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_tri_ready", tri_ready, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rel_ready", tri_ready, 1'b1);
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
